instr_fetch_unit: RTL
=====================

// Module: instr_fetch_unit
// PURPOSE
//  Front-end stage feeding seq_processor decode/execute. Owns the fetch PC,
//  issues in-order word requests to instruction memory over a valid/ready port,
//  buffers returned words with their PC in a small FIFO and hands them
//  downstream via valid/ready. Supports branch/jump redirect (flush) and
//  halts on the all-zero instruction used as the program terminator.
// PARAMETERS
//  PC_W       64             fetch address width (bits)
//  INSTR_W    32             instruction width (bits)
//  FIFO_DEPTH 4              prefetch entries, power of two, >=2
//  RESET_PC   64'h0          PC loaded on reset
// PORTS
//  clk             in   1        clock, all state on rising edge
//  reset           in   1        synchronous, active-high
//  imem_req_valid  out  1        request to instruction memory
//  imem_req_ready  in   1        memory accepts request this cycle
//  imem_req_addr   out  PC_W     word address of request (bits[1:0]=0)
//  imem_resp_valid in   1        response word present (in order, latency >=1)
//  imem_resp_data  in   INSTR_W  returned instruction
//  redirect_valid  in   1        taken branch/jump from execute
//  redirect_pc     in   PC_W     new fetch target
//  out_valid       out  1        FIFO head valid
//  out_ready       in   1        processor consumes head
//  out_pc          out  PC_W     PC of head instruction
//  out_instr       out  INSTR_W  head instruction
//  halted          out  1        terminator instruction consumed
// BEHAVIOUR
//  - Reset: pc=RESET_PC, FIFO empty, outstanding=0, drop=0, state RUN; outputs
//    imem_req_valid=0, out_valid=0, halted=0, out_pc/out_instr=0.
//  - States: RUN, HALT. RUN->HALT when an entry with instr==0 completes an
//    out handshake. HALT: no new requests, out_valid=0, halted=1; leaves only
//    on reset (redirect ignored in HALT).
//  - Request: imem_req_valid=1 in RUN when fifo_count+outstanding < FIFO_DEPTH
//    (credit rule; response can never overflow FIFO). Request fires on
//    valid&ready; then pc <= pc+4 (mod 2^PC_W, wraps), outstanding++.
//    imem_req_addr=pc, held stable while valid&!ready.
//  - Response: on imem_resp_valid, outstanding--. If drop>0: discard, drop--.
//    Else push {pc_tag, data}; pc_tag from an internal tag queue of issued PCs.
//  - Output: out_valid = !fifo_empty & RUN; pop on out_valid&out_ready.
//    Push to empty FIFO visible on out_valid the next cycle (1-cycle latency
//    response->output). Push and pop same cycle: count unchanged.
//  - Redirect (RUN, highest priority): FIFO and tag queue cleared, pc <=
//    {redirect_pc[PC_W-1:2],2'b00}, drop <= outstanding (minus any response
//    arriving that same cycle, which is itself discarded). A request
//    handshaking in the redirect cycle is counted into drop. A pop in the same
//    cycle is still a valid handshake (consumer owns it). First request to new
//    target may issue the cycle after redirect.
//  - Reset asserted mid-operation: all state returns to reset values next edge;
//    memory responses arriving after reset for pre-reset requests are the
//    memory's responsibility (memory is reset on same signal).
// STRUCTURE
//  - Shared package riscv_pkg: INSTR_W, OPC_* opcode constants, INSTR_HALT=32'h0,
//    PC_STEP=4, fetch_entry_t {pc, instr}.
//  - One sub-module: fetch_fifo (parameterised sync FIFO, push/pop/flush,
//    count output) instantiated for entries; tag queue may reuse it.
//  - Top holds PC, outstanding/drop counters and RUN/HALT FSM.
// TESTING
//  1 Reset, mem latency 1, always ready, out_ready=1: instrs at 0x0,0x4,0x8
//    appear in order with out_pc 0x0,0x4,0x8; first out_valid <=3 cycles post reset.
//  2 out_ready=0 for 20 cycles: exactly FIFO_DEPTH(4) requests issued, then
//    imem_req_valid=0; release -> 4 entries drain in order, fetch resumes at 0x10.
//  3 Latency 3, redirect to 0x100 with 2 in flight: both stale responses
//    dropped, next out_pc=0x100; redirect_pc=0x103 -> fetch 0x100.
//  4 imem_req_ready toggling 1/0: addr stable while stalled, no PC skipped/duplicated.
//  5 Program 0x00500093,0x00000000,0x00100113: after consuming 0x0 halted=1,
//    out_valid=0, no further requests; 3rd instr never delivered.
//  6 Reset asserted while FIFO holds 3 entries: next cycle out_valid=0,
//    imem_req_addr=RESET_PC, halted=0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the seq_processor front end.
// Contents: instruction width, RV32I major opcodes, the program terminator
// word, the sequential PC step, the fetch-entry record and the fetch FSM
// state encoding.
package riscv_pkg;

  localparam int INSTR_W  = 32;
  localparam int PC_W_DEF = 64;
  localparam int PC_STEP  = 4;

  // The all-zero word terminates a program.
  localparam logic [31:0] INSTR_HALT = 32'h0000_0000;

  // RV32I major opcodes (instr[6:0])
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef struct packed {
    logic [PC_W_DEF-1:0] pc;
    logic [INSTR_W-1:0]  instr;
  } fetch_entry_t;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO used for both the fetched-instruction buffer and the
// issued-PC tag queue.
// Ports:
//   clk, reset    rising-edge clock, synchronous active-high reset (pointers only)
//   push_i        write push_data_i (ignored when full and not popping)
//   pop_i         drop the head entry (ignored when empty)
//   flush_i       empty the FIFO; overrides push and pop
//   head_o        current head entry (contents undefined when empty)
//   empty_o       no entries held
//   count_o       number of entries held, 0..DEPTH
module fetch_fifo #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       push_data_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  output logic [WIDTH-1:0]       head_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             full, do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  // A pop frees the slot a simultaneous push needs.
  assign do_push = push_i & (~full | do_pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the fetch PC, issues in-order word
// requests to instruction memory, buffers returned words with their PC and
// hands them to decode. Redirects flush the buffer and discard responses to
// requests already in flight; consuming the all-zero word halts fetch until
// reset.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   imem_req_valid/ready/addr       request port to instruction memory
//   imem_resp_valid/data            in-order response port, latency >= 1
//   redirect_valid/pc               taken branch/jump target from execute
//   out_valid/ready/pc/instr        instruction stream to decode
//   halted                          terminator consumed, fetch stopped
module instr_fetch_unit #(
  parameter int              PC_W       = 64,
  parameter int              INSTR_W    = 32,
  parameter int              FIFO_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC   = '0
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [PC_W-1:0]    imem_req_addr,
  input  logic               imem_resp_valid,
  input  logic [INSTR_W-1:0] imem_resp_data,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic               halted
);

  import riscv_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int EW = PC_W + INSTR_W;

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [CW-1:0]   outst_q, outst_d;
  logic [CW-1:0]   drop_q, drop_d;

  logic            run, redir, credit_ok, req_fire, resp_keep, pop;
  logic [EW-1:0]   ent_head;
  logic            ent_empty;
  logic [CW-1:0]   ent_count;
  logic [PC_W-1:0] tag_head;
  logic            tag_empty;
  logic [CW-1:0]   tag_count;
  logic            unused_tag;

  assign run   = (state_q == ST_RUN);
  assign redir = redirect_valid & run;

  // Credit rule: every outstanding request already owns a buffer slot, so a
  // response can never find the entry FIFO full.
  assign credit_ok = ({1'b0, ent_count} + {1'b0, outst_q}) < (CW+1)'(FIFO_DEPTH);
  assign req_fire  = imem_req_valid & imem_req_ready;
  // Responses to pre-redirect requests are discarded while drop is non-zero;
  // one arriving in the redirect cycle itself is discarded as well.
  assign resp_keep = imem_resp_valid & (drop_q == '0) & ~redir;
  assign pop       = out_valid & out_ready;

  fetch_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_entries (
    .clk         (clk),
    .reset       (reset),
    .push_i      (resp_keep),
    .push_data_i ({tag_head, imem_resp_data}),
    .pop_i       (pop),
    .flush_i     (redir),
    .head_o      (ent_head),
    .empty_o     (ent_empty),
    .count_o     (ent_count)
  );

  // PCs of issued, still-wanted requests, in issue order; the head tags the
  // next kept response.
  fetch_fifo #(.WIDTH(PC_W), .DEPTH(FIFO_DEPTH)) u_tags (
    .clk         (clk),
    .reset       (reset),
    .push_i      (req_fire & ~redir),
    .push_data_i (pc_q),
    .pop_i       (resp_keep),
    .flush_i     (redir),
    .head_o      (tag_head),
    .empty_o     (tag_empty),
    .count_o     (tag_count)
  );

  assign unused_tag = ^{tag_empty, tag_count};

  always_comb begin
    outst_d = outst_q + CW'(req_fire) - CW'(imem_resp_valid);
    pc_d    = pc_q;
    drop_d  = drop_q;
    if (redir) begin
      pc_d   = {redirect_pc[PC_W-1:2], 2'b00};
      // Everything still in flight after this edge is stale.
      drop_d = outst_d;
    end else begin
      if (req_fire) pc_d = pc_q + PC_W'(PC_STEP);
      if (imem_resp_valid && drop_q != '0) drop_d = drop_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      outst_q <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      outst_q <= outst_d;
      drop_q  <= drop_d;
    end
  end

  // HALT is entered once decode accepts the terminator and is left only by reset.
  always_comb begin
    state_d = state_q;
    if (run && pop && ent_head[INSTR_W-1:0] == INSTR_W'(INSTR_HALT)) state_d = ST_HALT;
  end

  always_comb begin
    imem_req_valid = 1'b0;
    out_valid      = 1'b0;
    halted         = 1'b0;
    case (state_q)
      ST_RUN: begin
        imem_req_valid = ~reset & credit_ok;
        out_valid      = ~reset & ~ent_empty;
      end
      ST_HALT: halted = 1'b1;
      default: ;
    endcase
  end

  assign imem_req_addr = pc_q;
  // Entry storage is not reset, so the head is only shown while valid.
  assign out_pc        = out_valid ? ent_head[EW-1:INSTR_W] : '0;
  assign out_instr     = out_valid ? ent_head[INSTR_W-1:0]  : '0;

endmodule
